// File: rtl/cache_pkg.sv
// Shared types and width helpers for the instruction cache core.
// Default geometry here matches the 4-core MESI system build.
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ADDR = 2'd2
    } state_t;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_INDEX_W = 6;
    localparam int DEF_WAYS    = 4;

    function automatic int tag_width(input int addr_w, input int index_w);
        return addr_w - index_w;
    endfunction

    function automatic int age_width(input int ways);
        return $clog2(ways);
    endfunction

endpackage

// File: rtl/icache_lru.sv
// Per-set true-LRU age tracking and victim choice for the instruction cache.
// Age 0 is most recent; age WAYS-1 is the replacement candidate.
module icache_lru
    import cache_pkg::*;
#(
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int WAYS    = DEF_WAYS,
    localparam int AGE_W  = age_width(WAYS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_acc,
    input  logic [INDEX_W-1:0] i_acc_set,
    input  logic [AGE_W-1:0]   i_acc_way,
    input  logic [INDEX_W-1:0] i_vic_set,
    input  logic [WAYS-1:0]    i_vic_valid,
    output logic [AGE_W-1:0]   o_victim
);

    localparam int SETS = 1 << INDEX_W;

    logic [AGE_W-1:0] r_age [SETS][WAYS];
    logic [AGE_W-1:0] w_old_age;
    logic [WAYS-1:0]  w_is_oldest;
    logic             w_found;

    assign w_old_age = r_age[i_acc_set][i_acc_way];

    // Accessed way becomes youngest; only ways younger than it age by one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_age[s][w] <= AGE_W'(w);
                end
            end
        end else if (i_acc) begin
            for (int w = 0; w < WAYS; w++) begin
                if (AGE_W'(w) == i_acc_way) begin
                    r_age[i_acc_set][w] <= '0;
                end else if (r_age[i_acc_set][w] < w_old_age) begin
                    r_age[i_acc_set][w] <= r_age[i_acc_set][w] + AGE_W'(1);
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_oldest
            assign w_is_oldest[gi] = (r_age[i_vic_set][gi] == AGE_W'(WAYS - 1));
        end
    endgenerate

    // An empty way always beats evicting a live line.
    always_comb begin
        o_victim = '0;
        w_found  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!w_found && !i_vic_valid[w]) begin
                o_victim = AGE_W'(w);
                w_found  = 1'b1;
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (!w_found && w_is_oldest[w]) begin
                o_victim = AGE_W'(w);
                w_found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/icache_core.sv
// Set-associative one-word-per-line instruction cache with common-bus miss
// handling, snoop invalidation and single-cycle flush.
module icache_core
    import cache_pkg::*;
#(
    parameter int CORE_ID = 0,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int WAYS    = DEF_WAYS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              PrRd,
    input  logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] Data_Bus,
    output logic              Rd_Valid,
    output logic              CPU_stall,
    output logic              Com_Bus_Req_proc,
    input  logic              Com_Bus_Gnt_proc,
    output logic [ADDR_W-1:0] Address_Com_out,
    output logic              Address_Com_oe,
    input  logic [DATA_W-1:0] Data_Bus_Com,
    input  logic              Data_in_Bus,
    input  logic              Snoop_Inval,
    input  logic [ADDR_W-1:0] Snoop_Addr,
    input  logic              Flush
);

    localparam int SETS  = 1 << INDEX_W;
    localparam int TAG_W = tag_width(ADDR_W, INDEX_W);
    localparam int AGE_W = age_width(WAYS);

    generate
        if (CORE_ID < 0 || CORE_ID > 3 || WAYS < 2 || (WAYS & (WAYS - 1)) != 0) begin : g_param_check
            $error("icache_core: CORE_ID must be 0..3 and WAYS a power of two >= 2");
        end
    endgenerate

    state_t              r_state;
    logic [ADDR_W-1:0]   r_miss_addr;
    logic [DATA_W-1:0]   r_data_bus;
    logic                r_rd_valid;
    logic                r_cpu_stall;
    logic                r_bus_req;
    logic [ADDR_W-1:0]   r_addr_com_out;
    logic                r_addr_com_oe;

    logic [SETS-1:0]     r_valid    [WAYS];
    logic [TAG_W-1:0]    r_tag_mem  [WAYS][SETS];
    logic [DATA_W-1:0]   r_data_mem [WAYS][SETS];

    logic [INDEX_W-1:0]  w_rd_idx, w_fill_idx, w_snp_idx;
    logic [TAG_W-1:0]    w_rd_tag, w_fill_tag, w_snp_tag;
    logic [WAYS-1:0]     w_rd_hit, w_snp_hit, w_fill_set_valid;
    logic [AGE_W-1:0]    w_hit_way, w_victim, w_acc_way;
    logic [INDEX_W-1:0]  w_acc_set;
    logic [DATA_W-1:0]   w_hit_data;
    logic                w_hit_now, w_fill_now, w_snoop_fill;

    assign w_rd_idx   = Address[INDEX_W-1:0];
    assign w_rd_tag   = Address[ADDR_W-1:INDEX_W];
    assign w_fill_idx = r_miss_addr[INDEX_W-1:0];
    assign w_fill_tag = r_miss_addr[ADDR_W-1:INDEX_W];
    assign w_snp_idx  = Snoop_Addr[INDEX_W-1:0];
    assign w_snp_tag  = Snoop_Addr[ADDR_W-1:INDEX_W];

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way_cmp
            assign w_rd_hit[gi]  = r_valid[gi][w_rd_idx] && (r_tag_mem[gi][w_rd_idx] == w_rd_tag);
            assign w_snp_hit[gi] = r_valid[gi][w_snp_idx] && (r_tag_mem[gi][w_snp_idx] == w_snp_tag);
            assign w_fill_set_valid[gi] = r_valid[gi][w_fill_idx];
        end
    endgenerate

    always_comb begin
        w_hit_way  = '0;
        w_hit_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (w_rd_hit[w]) begin
                w_hit_way  = AGE_W'(w);
                w_hit_data = r_data_mem[w][w_rd_idx];
            end
        end
    end

    // A simultaneous flush turns a would-be hit into a miss.
    assign w_hit_now    = (r_state == ST_IDLE) && PrRd && (|w_rd_hit) && !Flush;
    assign w_fill_now   = (r_state == ST_ADDR) && Data_in_Bus;
    assign w_snoop_fill = w_fill_now && Snoop_Inval && (Snoop_Addr == r_miss_addr);
    assign w_acc_set    = w_fill_now ? w_fill_idx : w_rd_idx;
    assign w_acc_way    = w_fill_now ? w_victim : w_hit_way;

    icache_lru #(
        .INDEX_W (INDEX_W),
        .WAYS    (WAYS)
    ) u_lru (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_acc       (w_hit_now || w_fill_now),
        .i_acc_set   (w_acc_set),
        .i_acc_way   (w_acc_way),
        .i_vic_set   (w_fill_idx),
        .i_vic_valid (w_fill_set_valid),
        .o_victim    (w_victim)
    );

    // Order matters: flush, then fill install, then snoop clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int w = 0; w < WAYS; w++) begin
                r_valid[w] <= '0;
            end
        end else begin
            for (int w = 0; w < WAYS; w++) begin
                if (Flush) begin
                    r_valid[w] <= '0;
                end
                if (w_fill_now && (w_victim == AGE_W'(w)) && !w_snoop_fill) begin
                    r_valid[w][w_fill_idx] <= 1'b1;
                end
                if (Snoop_Inval && w_snp_hit[w]) begin
                    r_valid[w][w_snp_idx] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill_now) begin
            for (int w = 0; w < WAYS; w++) begin
                if (w_victim == AGE_W'(w)) begin
                    r_tag_mem[w][w_fill_idx]  <= w_fill_tag;
                    r_data_mem[w][w_fill_idx] <= Data_Bus_Com;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_miss_addr    <= '0;
            r_data_bus     <= '0;
            r_rd_valid     <= 1'b0;
            r_cpu_stall    <= 1'b0;
            r_bus_req      <= 1'b0;
            r_addr_com_out <= '0;
            r_addr_com_oe  <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_hit_now) begin
                        r_data_bus <= w_hit_data;
                        r_rd_valid <= 1'b1;
                    end else if (PrRd) begin
                        r_miss_addr <= Address;
                        r_cpu_stall <= 1'b1;
                        r_bus_req   <= 1'b1;
                        r_state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (Com_Bus_Gnt_proc) begin
                        r_addr_com_oe  <= 1'b1;
                        r_addr_com_out <= r_miss_addr;
                        r_state        <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    // Bus request is held through the data cycle to keep ownership.
                    if (Data_in_Bus) begin
                        r_data_bus     <= Data_Bus_Com;
                        r_rd_valid     <= 1'b1;
                        r_cpu_stall    <= 1'b0;
                        r_bus_req      <= 1'b0;
                        r_addr_com_oe  <= 1'b0;
                        r_addr_com_out <= '0;
                        r_state        <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign Data_Bus         = r_data_bus;
    assign Rd_Valid         = r_rd_valid;
    assign CPU_stall        = r_cpu_stall;
    assign Com_Bus_Req_proc = r_bus_req;
    assign Address_Com_out  = r_addr_com_out;
    assign Address_Com_oe   = r_addr_com_oe;

endmodule

// File: tb/tb_icache_core.sv
// Self-checking bench for icache_core: scenario tasks plus a read-data scoreboard.
module tb_icache_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        PrRd = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] Data_Bus;
    logic        Rd_Valid;
    logic        CPU_stall;
    logic        Com_Bus_Req_proc;
    logic        Com_Bus_Gnt_proc = 1'b0;
    logic [31:0] Address_Com_out;
    logic        Address_Com_oe;
    logic [31:0] Data_Bus_Com = '0;
    logic        Data_in_Bus = 1'b0;
    logic        Snoop_Inval = 1'b0;
    logic [31:0] Snoop_Addr = '0;
    logic        Flush = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] sb [$];

    always #5 clk = ~clk;

    icache_core #(
        .CORE_ID (1), .ADDR_W (32), .DATA_W (32), .INDEX_W (6), .WAYS (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .PrRd             (PrRd),
        .Address          (Address),
        .Data_Bus         (Data_Bus),
        .Rd_Valid         (Rd_Valid),
        .CPU_stall        (CPU_stall),
        .Com_Bus_Req_proc (Com_Bus_Req_proc),
        .Com_Bus_Gnt_proc (Com_Bus_Gnt_proc),
        .Address_Com_out  (Address_Com_out),
        .Address_Com_oe   (Address_Com_oe),
        .Data_Bus_Com     (Data_Bus_Com),
        .Data_in_Bus      (Data_in_Bus),
        .Snoop_Inval      (Snoop_Inval),
        .Snoop_Addr       (Snoop_Addr),
        .Flush            (Flush)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    // Scoreboard: every Rd_Valid pulse must match the oldest outstanding read.
    always @(negedge clk) begin
        if (Rd_Valid === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: Rd_Valid with Data_Bus=%h, required no pulse", Data_Bus);
            end else begin
                logic [31:0] exp_d;
                exp_d = sb.pop_front();
                if (Data_Bus !== exp_d) begin
                    n_fail++;
                    $display("FAIL sb_data: Data_Bus=%h required %h", Data_Bus, exp_d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_read(input logic [31:0] addr, input bit exp_hit, input int gnt_wait,
                           input bit flush_with_req, input bit snoop_at_fill,
                           input bit flush_in_req, input string name);
        logic [31:0] d;
        logic        exp_req;
        bit          got;
        d       = mem_word(addr);
        exp_req = exp_hit ? 1'b0 : 1'b1;
        sb.push_back(d);
        PrRd    = 1'b1;
        Address = addr;
        Flush   = flush_with_req;
        @(negedge clk);
        Flush = 1'b0;
        n_tests++;
        if (Com_Bus_Req_proc !== exp_req) begin
            n_fail++;
            $display("FAIL %s hit_miss: Req=%b required %b", name, Com_Bus_Req_proc, exp_req);
        end
        if (Com_Bus_Req_proc === 1'b1) begin
            n_tests++;
            if (CPU_stall !== 1'b1 || Address_Com_oe !== 1'b0 || Rd_Valid !== 1'b0) begin
                n_fail++;
                $display("FAIL %s miss_entry: stall=%b oe=%b rdv=%b required 1 0 0",
                         name, CPU_stall, Address_Com_oe, Rd_Valid);
            end
            for (int k = 0; k < gnt_wait; k++) begin
                if (k == 0 && flush_in_req) Flush = 1'b1;
                @(negedge clk);
                Flush = 1'b0;
                n_tests++;
                if (CPU_stall !== 1'b1 || Com_Bus_Req_proc !== 1'b1 || Address_Com_oe !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s grant_wait%0d: stall=%b req=%b oe=%b required 1 1 0",
                             name, k, CPU_stall, Com_Bus_Req_proc, Address_Com_oe);
                end
            end
            Com_Bus_Gnt_proc = 1'b1;
            @(negedge clk);
            Com_Bus_Gnt_proc = 1'b0;
            n_tests++;
            if (Address_Com_oe !== 1'b1 || Address_Com_out !== addr || Com_Bus_Req_proc !== 1'b1 ||
                CPU_stall !== 1'b1) begin
                n_fail++;
                $display("FAIL %s addr_phase: oe=%b addr=%h req=%b stall=%b required 1 %h 1 1",
                         name, Address_Com_oe, Address_Com_out, Com_Bus_Req_proc, CPU_stall, addr);
            end
            Data_in_Bus  = 1'b1;
            Data_Bus_Com = d;
            if (snoop_at_fill) begin
                Snoop_Inval = 1'b1;
                Snoop_Addr  = addr;
            end
            got = 1'b0;
            for (int k = 0; k < 4 && !got; k++) begin
                @(negedge clk);
                Snoop_Inval = 1'b0;
                if (Rd_Valid === 1'b1) got = 1'b1;
            end
            Data_in_Bus = 1'b0;
            n_tests++;
            if (!got || CPU_stall !== 1'b0 || Com_Bus_Req_proc !== 1'b0 || Address_Com_oe !== 1'b0) begin
                n_fail++;
                $display("FAIL %s fill: rdv_seen=%b stall=%b req=%b oe=%b required 1 0 0 0",
                         name, got, CPU_stall, Com_Bus_Req_proc, Address_Com_oe);
            end
        end else if (Rd_Valid !== 1'b1) begin
            void'(sb.pop_back());
            n_tests++;
            n_fail++;
            $display("FAIL %s no_response: Rd_Valid=%b Req=%b required a hit or a miss",
                     name, Rd_Valid, Com_Bus_Req_proc);
        end
        PrRd = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        n_tests++;
        if (Data_Bus !== 32'h0 || Rd_Valid !== 1'b0 || CPU_stall !== 1'b0 ||
            Com_Bus_Req_proc !== 1'b0 || Address_Com_out !== 32'h0 || Address_Com_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL %s outputs: data=%h rdv=%b stall=%b req=%b addr=%h oe=%b required all 0",
                     name, Data_Bus, Rd_Valid, CPU_stall, Com_Bus_Req_proc, Address_Com_out, Address_Com_oe);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset_idle");
    endtask

    task automatic test_miss_hit();
        do_read(32'h040, 1'b0, 0, 1'b0, 1'b0, 1'b0, "miss_0x040");
        do_read(32'h040, 1'b1, 0, 1'b0, 1'b0, 1'b0, "hit_0x040");
    endtask

    // Ways fill 0..3 in order; 0x140 evicts the oldest (0x040).
    task automatic test_eviction();
        do_read(32'h080, 1'b0, 1, 1'b0, 1'b0, 1'b0, "fill_0x080");
        do_read(32'h0C0, 1'b0, 0, 1'b0, 1'b0, 1'b0, "fill_0x0C0");
        do_read(32'h100, 1'b0, 2, 1'b0, 1'b0, 1'b0, "fill_0x100");
        do_read(32'h140, 1'b0, 0, 1'b0, 1'b0, 1'b0, "fill_0x140");
        do_read(32'h080, 1'b1, 0, 1'b0, 1'b0, 1'b0, "evict_keep_0x080");
        do_read(32'h040, 1'b0, 0, 1'b0, 1'b0, 1'b0, "evict_gone_0x040");
        do_read(32'h0C0, 1'b0, 0, 1'b0, 1'b0, 1'b0, "lru_victim_0x0C0");
    endtask

    task automatic snoop_pulse(input logic [31:0] a);
        Snoop_Inval = 1'b1;
        Snoop_Addr  = a;
        @(negedge clk);
        Snoop_Inval = 1'b0;
    endtask

    task automatic test_snoop();
        snoop_pulse(32'h0C0);
        do_read(32'h040, 1'b1, 0, 1'b0, 1'b0, 1'b0, "snoop_other_0x040");
        snoop_pulse(32'h040);
        do_read(32'h040, 1'b0, 0, 1'b0, 1'b0, 1'b0, "snoop_inval_0x040");
        do_read(32'h0C0, 1'b0, 0, 1'b0, 1'b0, 1'b0, "snoop_inval_0x0C0");
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        addrs = '{32'h040, 32'h080, 32'h140};
        for (int i = 0; i < 3; i++) begin
            sb.push_back(mem_word(addrs[i]));
            PrRd    = 1'b1;
            Address = addrs[i];
            @(negedge clk);
            n_tests++;
            if (Rd_Valid !== 1'b1 || Com_Bus_Req_proc !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_%0d: rdv=%b req=%b required 1 0", i, Rd_Valid, Com_Bus_Req_proc);
                if (Rd_Valid !== 1'b1) void'(sb.pop_back());
            end
        end
        PrRd = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_grant_withheld();
        do_read(32'h180, 1'b0, 10, 1'b0, 1'b0, 1'b0, "grant_withheld");
    endtask

    task automatic test_reset_mid_miss();
        do_read(32'h080, 1'b1, 0, 1'b0, 1'b0, 1'b0, "pre_reset_0x080");
        PrRd    = 1'b1;
        Address = 32'h1C0;
        @(negedge clk);
        Com_Bus_Gnt_proc = 1'b1;
        @(negedge clk);
        Com_Bus_Gnt_proc = 1'b0;
        n_tests++;
        if (Address_Com_oe !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_miss_addr: oe=%b required 1", Address_Com_oe);
        end
        rst_n = 1'b0;
        PrRd  = 1'b0;
        @(negedge clk);
        check_all_zero("rst_mid_miss");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("rst_mid_miss_after");
        do_read(32'h080, 1'b0, 0, 1'b0, 1'b0, 1'b0, "post_reset_0x080");
    endtask

    task automatic test_collisions();
        do_read(32'h200, 1'b0, 0, 1'b0, 1'b1, 1'b0, "snoop_fill_0x200");
        do_read(32'h200, 1'b0, 0, 1'b0, 1'b0, 1'b0, "after_snoop_fill_0x200");
        do_read(32'h200, 1'b0, 0, 1'b1, 1'b0, 1'b0, "flush_with_req_0x200");
        do_read(32'h280, 1'b0, 2, 1'b0, 1'b0, 1'b1, "flush_in_miss_0x280");
        do_read(32'h280, 1'b1, 0, 1'b0, 1'b0, 1'b0, "flush_in_miss_kept_0x280");
    endtask

    initial begin
        test_reset();
        test_miss_hit();
        test_eviction();
        test_snoop();
        test_back_to_back();
        test_grant_withheld();
        test_reset_mid_miss();
        test_collisions();
        repeat (2) @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d reads outstanding, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
